uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Serial receiver for the external COM link; the receive-side counterpart of the existing UART transmit path.
- Accepts 8N1 frames (1 start, 8 data LSB-first, 1 stop) on an asynchronous line and oversamples at CLKS_PER_BIT system clocks per bit.
- Delivers each byte on a held data register with a valid pulse, pending flag, frame-error and overrun flags.
- Exports its FSM state for LED debug, the same way the transmit FSM state is exported.

Parameters:
- CLKS_PER_BIT, 8, system clock cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this block.

Ports:
- clk  input  1  system clock, the divided bus clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_ack  input  1  consumer has read rx_data; clears rx_pending.
- rx_data  output  8  last correctly framed byte; held until the next good byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- rx_pending  output  1  unread byte present.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a good byte lands while rx_pending=1 and rx_ack=0.
- busy  output  1  high in any state other than IDLE.
- state_rx  output  3  FSM state code, for debug LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - rx_data=0x00; rx_valid, rx_pending, frame_err, overrun, busy = 0; state_rx=IDLE.
  - Synchronizer flops preset to 1; counters and shift register cleared.
  - Reset mid-frame aborts the frame immediately; no partial byte is ever output.
- Input sync: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- Bit counter: cnt counts clk cycles. HALF = CLKS_PER_BIT/2 (integer). bit_idx runs 0..7.
- State codes: IDLE=0, START=1, DATA=2, STOP=3, DONE=4; codes 5..7 go to IDLE.
- IDLE: cnt=0. When rx_s=0, go to START.
- START: cnt increments. When cnt=HALF-1, sample rx_s:
  - rx_s=0: go to DATA, cnt=0, bit_idx=0.
  - rx_s=1 (glitch): go to IDLE with no outputs.
- DATA: cnt increments. When cnt=CLKS_PER_BIT-1, shift rx_s into shift[bit_idx] (LSB first) and set cnt=0.
  - bit_idx=7: go to STOP.
  - otherwise: bit_idx+1.
- STOP: when cnt=CLKS_PER_BIT-1, sample rx_s:
  - rx_s=1: next cycle rx_data=shift and rx_valid=1, then go to DONE.
  - rx_s=0: next cycle frame_err=1, rx_data unchanged, rx_pending unchanged, then go to DONE.
- DONE: one cycle, then IDLE. Start-bit detection is therefore possible on the 2nd cycle after the stop sample, which tolerates back-to-back frames.
- rx_pending:
  - Set on rx_valid; cleared on rx_ack.
  - rx_ack and rx_valid in the same cycle: rx_pending stays 1 and no overrun.
  - rx_ack while rx_pending=0 has no effect.
- overrun: asserted together with rx_valid when rx_pending=1 and rx_ack=0. The new byte overwrites rx_data.
- Latency: rx_valid rises 9*CLKS_PER_BIT + HALF + 4 cycles (±1) after the rx falling edge of the start bit.
- rx_valid, frame_err and overrun are mutually exclusive, except overrun, which coincides with rx_valid.

Test Plan:
- CLKS_PER_BIT=8; send 0xA5 with a good stop bit -> rx_data=0xA5, rx_valid exactly 1 cycle at 9*8+4+4 ±1 cycles, rx_pending=1, frame_err=0, state sequence 0,1,2,3,4,0.
- Then send 0x3C with the stop bit driven low -> frame_err 1-cycle pulse, rx_valid=0, rx_data stays 0xA5.
- Pull rx low for 2 cycles only -> state goes 0→1→0, busy drops, no rx_valid, no frame_err.
- Send 0x11 then 0x22 back-to-back with no rx_ack -> second rx_valid coincides with overrun=1, rx_data=0x22; then pulse rx_ack -> rx_pending=0.
- Assert rx_ack in the same cycle as rx_valid for a pending byte -> rx_pending remains 1, overrun=0.
- Pull reset low in the DATA state at bit 4 -> all outputs 0 and state_rx=0 immediately; release reset, send 0x5A -> rx_data=0x5A received cleanly.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle of the COM link: serial line and consumer ack in,
// framed byte with status pulses and debug state out.
interface uart_rx_frame_if;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pending;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] state_rx;

    modport slave (
        input  rx, rx_ack,
        output rx_data, rx_valid, rx_pending, frame_err, overrun, busy, state_rx
    );

    modport master (
        output rx, rx_ack,
        input  rx_data, rx_valid, rx_pending, frame_err, overrun, busy, state_rx
    );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver, CLKS_PER_BIT oversampling; rx_valid ~9*CPB+HALF+3 clocks after the start edge.
// No backpressure: bytes are held in rx_data, and a byte arriving while one is still unread flags overrun.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_frame_if.slave bus
);
    localparam int         HALF     = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        pending_q, pending_d;
    logic        ferr_q, ferr_d;
    logic        old_pend_q, old_pend_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
            ferr_q     <= 1'b0;
            old_pend_q <= 1'b0;
        end else begin
            rx_meta_q  <= bus.rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            ferr_q     <= ferr_d;
            old_pend_q <= old_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        old_pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == LAST_BIT) state_d = S_STOP;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (rx_s_q) begin
                        data_d     = shift_q;
                        valid_d    = 1'b1;
                        // An ack in this cycle still reads the old byte, so it is not lost.
                        old_pend_d = pending_q & ~bus.rx_ack;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // An ack coinciding with rx_valid refers to the previous byte, so the new one stays pending.
    always_comb begin
        pending_d = pending_q;
        if (valid_d)                      pending_d = 1'b1;
        else if (bus.rx_ack && !valid_q)  pending_d = 1'b0;
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.rx_pending = pending_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = valid_q & old_pend_q & ~bus.rx_ack;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.state_rx   = state_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at CLKS_PER_BIT=8 with a negedge monitor logging pulses and state changes.
module tb_uart_rx_frame;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_frame_if bus();

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          vcnt = 0, vrun = 0, vmax = 0, vcyc = 0;
    int          fecnt = 0, ferun = 0, femax = 0;
    int          stray_ovr = 0, ntrans = 0;
    logic [7:0]  ovr_hist = '0;
    logic [31:0] trace = '0;
    logic [2:0]  prev_st = '0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            vcnt     <= vcnt + 1;
            vcyc     <= cyc;
            ovr_hist <= {ovr_hist[6:0], bus.overrun};
            vrun     <= vrun + 1;
            if (vrun + 1 > vmax) vmax <= vrun + 1;
        end else begin
            vrun <= 0;
        end
        if (bus.frame_err) begin
            fecnt <= fecnt + 1;
            ferun <= ferun + 1;
            if (ferun + 1 > femax) femax <= ferun + 1;
        end else begin
            ferun <= 0;
        end
        if (bus.overrun && !bus.rx_valid) stray_ovr <= stray_ovr + 1;
        if (bus.state_rx != prev_st) begin
            trace   <= {trace[28:0], bus.state_rx};
            ntrans  <= ntrans + 1;
            prev_st <= bus.state_rx;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(CPB);
        end
        bus.rx = stop;
        tick(CPB);
        bus.rx = 1'b1;
    endtask

    task automatic chk_cleared(input string pfx);
        chk({pfx, "_data"},    32'(bus.rx_data),    32'h00);
        chk({pfx, "_valid"},   32'(bus.rx_valid),   32'd0);
        chk({pfx, "_pending"}, 32'(bus.rx_pending), 32'd0);
        chk({pfx, "_ferr"},    32'(bus.frame_err),  32'd0);
        chk({pfx, "_ovr"},     32'(bus.overrun),    32'd0);
        chk({pfx, "_busy"},    32'(bus.busy),       32'd0);
        chk({pfx, "_state"},   32'(bus.state_rx),   32'd0);
    endtask

    initial begin
        int t0, v0, f0, tr0, lat;
        bit found;

        bus.rx     = 1'b1;
        bus.rx_ack = 1'b0;
        reset      = 1'b0;
        #23;
        chk_cleared("rst");
        @(posedge clk); #1;
        reset = 1'b1;
        tick(5);

        // Good frame 0xA5
        t0 = cyc; v0 = vcnt; f0 = fecnt; tr0 = ntrans;
        send_byte(8'hA5, 1'b1);
        tick(20);
        lat = vcyc - t0;
        chk("t1_vcnt",    32'(vcnt - v0), 32'd1);
        chk("t1_latency", 32'((lat >= 79 && lat <= 81) ? 79 : lat), 32'd79);
        chk("t1_data",    32'(bus.rx_data), 32'hA5);
        chk("t1_pending", 32'(bus.rx_pending), 32'd1);
        chk("t1_vwidth",  32'(vmax), 32'd1);
        chk("t1_noferr",  32'(fecnt - f0), 32'd0);
        chk("t1_ntrans",  32'(ntrans - tr0), 32'd5);
        chk("t1_states",  32'(trace[14:0]), 32'o12340);

        // Frame with low stop bit
        v0 = vcnt; f0 = fecnt;
        send_byte(8'h3C, 1'b0);
        tick(20);
        chk("t2_ferr",    32'(fecnt - f0), 32'd1);
        chk("t2_fwidth",  32'(femax), 32'd1);
        chk("t2_novalid", 32'(vcnt - v0), 32'd0);
        chk("t2_data",    32'(bus.rx_data), 32'hA5);
        chk("t2_pending", 32'(bus.rx_pending), 32'd1);

        // Two-cycle glitch
        v0 = vcnt; f0 = fecnt; tr0 = ntrans;
        bus.rx = 1'b0;
        tick(2);
        bus.rx = 1'b1;
        tick(20);
        chk("t3_ntrans",  32'(ntrans - tr0), 32'd2);
        chk("t3_states",  32'(trace[5:0]), 32'o10);
        chk("t3_busy",    32'(bus.busy), 32'd0);
        chk("t3_novalid", 32'(vcnt - v0), 32'd0);
        chk("t3_noferr",  32'(fecnt - f0), 32'd0);

        bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
        chk("ack1_pending", 32'(bus.rx_pending), 32'd0);

        // Back-to-back frames without ack
        v0 = vcnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(20);
        chk("t4_vcnt",    32'(vcnt - v0), 32'd2);
        chk("t4_data",    32'(bus.rx_data), 32'h22);
        chk("t4_ovr",     32'(ovr_hist[1:0]), 32'b01);
        chk("t4_pending", 32'(bus.rx_pending), 32'd1);
        bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
        chk("t4_ack_pending", 32'(bus.rx_pending), 32'd0);

        // Ack coinciding with rx_valid of a new byte while one is pending
        send_byte(8'h77, 1'b1);
        tick(20);
        chk("t5_first_pending", 32'(bus.rx_pending), 32'd1);
        chk("t5_first_ovr",     32'(ovr_hist[0]), 32'd0);
        found = 1'b0;
        fork
            send_byte(8'h88, 1'b1);
            begin
                for (int i = 0; i < 200 && !found; i++) begin
                    @(posedge clk); #1;
                    if (bus.rx_valid) found = 1'b1;
                end
                if (found) begin
                    bus.rx_ack = 1'b1;
                    #1;
                    chk("t5_ovr",  32'(bus.overrun), 32'd0);
                    chk("t5_data", 32'(bus.rx_data), 32'h88);
                    @(posedge clk); #1;
                    bus.rx_ack = 1'b0;
                    chk("t5_pending", 32'(bus.rx_pending), 32'd1);
                end
            end
        join
        chk("t5_valid_seen", 32'(found), 32'd1);
        tick(20);
        chk("stray_ovr", 32'(stray_ovr), 32'd0);

        // Reset in the middle of data bit 4
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0];
            tick(CPB);
        end
        bus.rx = 1'b1;
        tick(4);
        chk("t6_in_data", 32'(bus.state_rx), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_cleared("t6_rst");
        tick(3);
        reset = 1'b1;
        tick(20);
        v0 = vcnt;
        send_byte(8'h5A, 1'b1);
        tick(20);
        chk("t6_vcnt",    32'(vcnt - v0), 32'd1);
        chk("t6_data",    32'(bus.rx_data), 32'h5A);
        chk("t6_pending", 32'(bus.rx_pending), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
